// File: rtl/fb_line_reader.sv
// rtl/fb_line_reader.sv - ping-pong line buffer read engine with 2-entry skid FIFO
module fb_line_reader #(
  parameter int DATA     = 36,
  parameter int ADDR     = 9,
  parameter int LINE_LEN = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fill_done,
  input  logic            fill_bank,
  output logic            bank_free,
  output logic            free_bank,
  output logic [ADDR-1:0] rd_addr,
  input  logic [DATA-1:0] rd_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DATA-1:0] m_data,
  output logic            m_sol,
  output logic            m_eol,
  output logic            ovf_err
);

  localparam int IW = ADDR - 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LINE_LEN - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [1:0]      bank_full;
  logic            cur_bank;
  logic [IW-1:0]   idx;
  logic [ADDR-1:0] addr_q;
  logic            rd_issue;
  logic            start_line;
  logic            inflight;
  logic            inflight_sol;
  logic            inflight_eol;
  logic [DATA+1:0] fifo_mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic [1:0]      used;
  logic            push;
  logic            pop;
  logic            free_now;

  // FIFO head drives the stream directly, so a stalled word cannot change.
  assign m_valid = (count != 2'd0);
  assign {m_sol, m_eol, m_data} = fifo_mem[rd_ptr];
  assign pop      = m_valid & m_ready;
  assign push     = inflight;
  assign free_now = (state == DRAIN) & pop & m_eol;

  // Slots committed after this cycle's pop; a read needs one free slot.
  assign used = count + {1'b0, inflight} - {1'b0, pop};

  // The address only moves on an issued read; otherwise the last one is held.
  assign rd_addr = rd_issue ? {cur_bank, idx} : addr_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and credit-gated read issue
  always_comb begin
    state_nxt  = state;
    rd_issue   = 1'b0;
    start_line = 1'b0;
    case (state)
      IDLE: begin
        if (bank_full[cur_bank]) begin
          state_nxt  = STREAM;
          start_line = 1'b1;
        end
      end
      STREAM: begin
        rd_issue = ~used[1];
        if (rd_issue && idx == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (free_now) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word index, address hold and the one-deep in-flight read with its tags
  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      addr_q       <= '0;
      inflight     <= 1'b0;
      inflight_sol <= 1'b0;
      inflight_eol <= 1'b0;
    end else begin
      inflight     <= rd_issue;
      inflight_sol <= (idx == '0);
      inflight_eol <= (idx == LAST_IDX);
      addr_q       <= rd_addr;
      if (start_line)    idx <= '0;
      else if (rd_issue) idx <= idx + IW'(1);
    end
  end

  // Skid FIFO capturing RAM data one clock after its read was issued
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {inflight_sol, inflight_eol, rd_data};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Bank ownership: fills mark banks full, the accepted eol frees the current one
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full <= 2'b00;
      cur_bank  <= 1'b0;
      bank_free <= 1'b0;
      free_bank <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      bank_free <= free_now;
      free_bank <= free_now & cur_bank;
      if (fill_done) begin
        if (bank_full[fill_bank] || (state != IDLE && fill_bank == cur_bank))
          ovf_err <= 1'b1;
        else
          bank_full[fill_bank] <= 1'b1;
      end
      // Placed after the fill update so a same-cycle refill of this bank loses.
      if (free_now) begin
        bank_full[cur_bank] <= 1'b0;
        cur_bank            <= ~cur_bank;
      end
    end
  end

endmodule

// File: tb/tb_fb_line_reader.sv
// tb/tb_fb_line_reader.sv - randomized scoreboard bench for fb_line_reader over several line lengths
module tb_fb_line_reader;

  localparam int DATA = 36;
  localparam int ADDR = 9;
  localparam int NL   = 4;
  localparam int PP_CYCLES = 530;

  logic clk = 1'b0;
  logic rst;
  logic fill_done;
  logic fill_bank;
  logic m_ready;
  logic pp_rec;
  logic pp_check;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar k = 0; k < NL; k++) begin : g_lane
    localparam int L = (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 16 : 256;

    logic            bank_free;
    logic            free_bank;
    logic            m_valid;
    logic            m_sol;
    logic            m_eol;
    logic            ovf_err;
    logic [ADDR-1:0] rd_addr;
    logic [DATA-1:0] rd_data;
    logic [DATA-1:0] m_data;
    logic [DATA-1:0] ram [2**ADDR];

    fb_line_reader #(.DATA(DATA), .ADDR(ADDR), .LINE_LEN(L)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .fill_done (fill_done),
      .fill_bank (fill_bank),
      .bank_free (bank_free),
      .free_bank (free_bank),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_sol     (m_sol),
      .m_eol     (m_eol),
      .ovf_err   (ovf_err)
    );

    initial for (int i = 0; i < 2**ADDR; i++) ram[i] = '0;

    // Dual-port RAM read side: one clock of latency
    always @(posedge clk) rd_data <= ram[rd_addr];

    // Reference model: two bank flags, the bank owed next, position within its line
    bit              m_full [2];
    bit              m_cur;
    int              m_pos;
    bit              m_ovf;
    bit              exp_free;
    bit              exp_fbank;
    bit              rst_prev;
    bit              prev_stall;
    logic [DATA-1:0] prev_d;
    logic            prev_sol;
    logic            prev_eol;
    bit              hist [$];

    always @(negedge clk) begin
      string p;
      bit    xfer;
      bit    free_now;
      int    base;
      int    bad;
      bit    e;
      p = $sformatf("len%0d", L);

      if (rst_prev) begin
        check_val({p, " rst_m_valid"},   m_valid,   0);
        check_val({p, " rst_m_data"},    m_data,    0);
        check_val({p, " rst_m_sol"},     m_sol,     0);
        check_val({p, " rst_m_eol"},     m_eol,     0);
        check_val({p, " rst_bank_free"}, bank_free, 0);
        check_val({p, " rst_free_bank"}, free_bank, 0);
        check_val({p, " rst_rd_addr"},   rd_addr,   0);
      end
      check_val({p, " ovf_err"},   ovf_err,   m_ovf);
      check_val({p, " bank_free"}, bank_free, exp_free);
      if (exp_free) check_val({p, " free_bank"}, free_bank, exp_fbank);

      if (prev_stall) begin
        check_val({p, " stall_valid"}, m_valid, 1);
        check_val({p, " stall_data"},  m_data,  prev_d);
        check_val({p, " stall_sol"},   m_sol,   prev_sol);
        check_val({p, " stall_eol"},   m_eol,   prev_eol);
      end

      if (!m_full[m_cur]) check_val({p, " valid_without_line"}, m_valid, 0);
      else if (m_valid)   check_val({p, " rd_addr_bank"}, rd_addr[ADDR-1], m_cur);

      xfer       = m_valid && m_ready && m_full[m_cur];
      free_now   = 1'b0;
      prev_stall = m_valid && !m_ready && !rst;
      prev_d     = m_data;
      prev_sol   = m_sol;
      prev_eol   = m_eol;

      if (pp_rec) hist.push_back(m_valid);
      if (pp_check) begin
        // Latency from fill to first word is 3 empty samples; 3 more between lines.
        bad = 0;
        for (int i = 0; i < hist.size(); i++) begin
          e = (i >= 3 && i < 3 + L) || (i >= 6 + L && i < 6 + 2 * L);
          if (hist[i] != e) bad++;
        end
        check_val({p, " pingpong_valid_pattern_errors"}, bad, 0);
        hist.delete();
      end

      if (rst) begin
        m_full[0] = 0;
        m_full[1] = 0;
        m_cur     = 0;
        m_pos     = 0;
        m_ovf     = 0;
        exp_free  = 0;
        rst_prev  = 1;
      end else begin
        rst_prev = 0;
        if (xfer) begin
          base = int'(m_cur) << (ADDR - 1);
          check_val({p, " data"}, m_data, ram[base + m_pos]);
          check_val({p, " sol"},  m_sol,  m_pos == 0);
          check_val({p, " eol"},  m_eol,  m_pos == L - 1);
          if (m_pos == L - 1) free_now = 1'b1;
          else                m_pos++;
        end
        if (fill_done) begin
          if (m_full[fill_bank]) m_ovf = 1;
          else begin
            m_full[fill_bank] = 1;
            base = int'(fill_bank) << (ADDR - 1);
            for (int i = 0; i < L; i++) ram[base + i] = DATA'({$urandom(), $urandom()});
          end
        end
        exp_free  = free_now;
        exp_fbank = m_cur;
        if (free_now) begin
          m_full[m_cur] = 0;
          m_cur         = ~m_cur;
          m_pos         = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    fill_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fill(input bit b);
    fill_done = 1'b1;
    fill_bank = b;
    tick();
    fill_done = 1'b0;
  endtask

  initial begin
    bit pat [6];
    int rdy_pct;
    pat = '{1, 0, 0, 1, 0, 1};
    rst       = 1'b1;
    fill_done = 1'b0;
    fill_bank = 1'b0;
    m_ready   = 1'b0;
    pp_rec    = 1'b0;
    pp_check  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Back-to-back lines from both banks at full rate
    m_ready   = 1'b1;
    fill_done = 1'b1;
    fill_bank = 1'b0;
    tick();
    fill_bank = 1'b1;
    pp_rec    = 1'b1;
    tick();
    fill_done = 1'b0;
    repeat (PP_CYCLES - 1) tick();
    pp_rec   = 1'b0;
    pp_check = 1'b1;
    tick();
    pp_check = 1'b0;

    // Backpressure with a fixed ready pattern
    do_reset();
    for (int i = 0; i < 700; i++) begin
      m_ready   = pat[i % 6];
      fill_done = (i == 0) || (i == 1);
      fill_bank = (i == 1);
      tick();
    end
    fill_done = 1'b0;

    // Word held under a long stall, then accepted once
    do_reset();
    m_ready = 1'b0;
    fill(1'b0);
    repeat (8) tick();
    m_ready = 1'b1;
    repeat (300) tick();

    // Overflow: double fill, then a third while the bank streams
    do_reset();
    m_ready = 1'b0;
    fill(1'b0);
    fill(1'b0);
    repeat (3) tick();
    fill(1'b0);
    m_ready = 1'b1;
    repeat (300) tick();

    // Reset in the middle of a line, then a fresh line
    do_reset();
    m_ready = 1'b1;
    fill(1'b0);
    repeat (5) tick();
    do_reset();
    fill(1'b0);
    repeat (300) tick();

    // Randomized traffic with occasional resets
    rdy_pct = 70;
    for (int i = 0; i < 6000; i++) begin
      if (i % 200 == 0) rdy_pct = $urandom_range(20, 100);
      rst       = ($urandom_range(0, 699) == 0);
      fill_done = ($urandom_range(0, 9) == 0);
      fill_bank = 1'($urandom_range(0, 1));
      m_ready   = ($urandom_range(0, 99) < rdy_pct);
      tick();
    end
    rst       = 1'b0;
    fill_done = 1'b0;
    m_ready   = 1'b1;
    repeat (600) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_line_reader.md
Name: fb_line_reader

Overview:
- Read-side engine for the framebuffer's ping-pong line buffer, held in the dual-port RAM.
- The write side fills one bank per line and announces it with fill_done.
- This block drives the RAM read port, absorbs its 1-cycle read latency, and streams each line downstream over a valid/ready interface with start/end-of-line flags.
- When a line has been fully accepted downstream, it returns the bank to the writer.

Parameters:
- DATA, 36, RAM word / pixel word width.
- ADDR, 9, RAM address width. MSB is the bank select; the low ADDR-1 bits are the word index.
- LINE_LEN, 256, words per line. Legal range 1..2**(ADDR-1).

Ports:
- clk  input  1  sole clock. The RAM read port is clocked from the same clk.
- rst  input  1  synchronous, active-high reset.
- fill_done  input  1  1-cycle pulse: writer finished bank fill_bank.
- fill_bank  input  1  bank index qualifying fill_done.
- bank_free  output  1  1-cycle pulse: bank free_bank may be refilled.
- free_bank  output  1  bank index qualifying bank_free.
- rd_addr  output  ADDR  RAM read address {bank, index}.
- rd_data  input  DATA  RAM read data, valid 1 clk after rd_addr is sampled.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.
- m_data  output  DATA  output word.
- m_sol  output  1  m_data is word 0 of a line.
- m_eol  output  1  m_data is word LINE_LEN-1 of a line.
- ovf_err  output  1  sticky: fill_done received for a bank that is already full or currently being read.

Behaviour:
- Reset: clk rising edge with rst=1 gives:
  - all outputs 0;
  - bank_full=2'b00, cur_bank=0, state IDLE;
  - skid buffer empty, no read in flight.
- Reset mid-line aborts the line with no bank_free pulse. Any word presented that cycle is dropped.
- bank_full[b] is set by fill_done with fill_bank=b.
- ovf_err is set if that bank is already full or is being streamed; bank_full is then left unchanged.
- A word transfers when m_valid & m_ready are both 1 on the same edge.
- m_data, m_sol and m_eol are held stable while m_valid=1 and m_ready=0.
- Read pipeline:
  - A read is issued on cycle t by presenting rd_addr and asserting an internal rd_issue; the word lands in the 2-entry skid FIFO at t+1.
  - A read may issue only if FIFO occupancy + reads in flight < 2, counting a pop in the same cycle. No overflow is possible.
  - With m_ready held at 1, throughput is 1 word/clk after a 2-clk startup (first m_valid 2 clks after the STREAM entry edge).
  - The index counter counts reads issued, 0..LINE_LEN-1. The sol and eol tags travel with each word through the FIFO.
- State machine:
  - IDLE: if bank_full[cur_bank]=1, go to STREAM and set the index to 0.
  - STREAM: issue reads as credit allows. After issuing index LINE_LEN-1, go to DRAIN.
  - DRAIN: no reads. When the eol word transfers:
    - clear bank_full[cur_bank];
    - pulse bank_free with free_bank=cur_bank for 1 clk;
    - toggle cur_bank;
    - return to IDLE.
  - IDLE with the other bank already full enters STREAM on the next edge, so back-to-back lines have exactly 1 IDLE cycle.
- LINE_LEN=1: one read is issued, then DRAIN. That word carries m_sol=1 and m_eol=1 together.
- Same-cycle events:
  - fill_done for the non-current bank, coinciding with that bank's bank_free, sets bank_full.
  - fill_done for the bank being freed in the same cycle is ovf_err. The freeing takes priority and the bank ends empty.
- Banks are always consumed in strict alternation 0,1,0,1… A full non-current bank waits.
- rd_addr is held at its last value when no read is issued. The RAM read port is free-running, so extra reads are harmless.
- ovf_err is cleared only by rst.

Test Plan:
- Basic line: LINE_LEN=4, RAM bank0 idx0..3 = 0x10..0x13, fill_done bank0, m_ready=1.
  - Required: m_data 0x10,0x11,0x12,0x13 on consecutive clks.
  - sol on 0x10, eol on 0x13.
  - bank_free=1 with free_bank=0 one clk after the 0x13 transfer.
- Backpressure: the same line with m_ready toggling 1,0,0,1,0,1…
  - Required: data order and flags are preserved, nothing is duplicated or lost.
  - m_data is stable during every stall, and bank_free fires only after eol is accepted.
- Ping-pong: fill bank0 and bank1 back-to-back with LINE_LEN=256 and m_ready=1.
  - Required: 512 words, bank0 first, exactly 1 idle cycle between lines.
  - bank_free sequence is 0 then 1, and rd_addr MSB follows cur_bank.
- Overflow: fill_done bank0 twice before bank0 is consumed.
  - Required: ovf_err=1 and stays 1; bank0 streams exactly once.
  - A third fill_done for bank0 during its STREAM also leaves ovf_err=1.
- Reset mid-line: assert rst after 2 of 4 words.
  - Required: next clk m_valid=0, bank_free=0, ovf_err=0.
  - A new fill_done bank0 streams from idx0 with sol=1.
- LINE_LEN=1 with m_ready=0 for 5 clks, then 1.
  - Required: a single word with sol=eol=1, held for 5 clks, accepted once; bank_free follows.
